pipe_mem_stage: RTL and testbench

Parametrised memory-access (MA) pipeline stage sitting between the execute stage and write-back. It accepts one EX result per valid/ready handshake and issues at most one load or store to the data cache over a req/ack handshake. Load data is sign- or zero-extended to the datapath width, and the write-back bundle is presented downstream under its own valid/ready handshake. Successor to the single-width, event-driven MA stage: fully clocked, supports datapath widths up to 64 bits, handles backpressure, and flags illegal accesses.

---
 rtl/pipe_mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_mem_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: memory-access pipeline stage between EX and WB.
// Accepts one EX bundle per valid/ready handshake, issues at most one cache
// load/store over req/ack, extends load data and presents the WB bundle
// under its own valid/ready handshake.
// Optional feature macro: MA_ALIGN_CHECK_EN (misaligned accesses fault).
module pipe_mem_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_rw_e,
    input  logic [1:0]        in_rw_len,
    input  logic [DATA_W-1:0] in_ans,
    input  logic [DATA_W-1:0] in_din,
    input  logic              in_wb_e,
    input  logic [4:0]        in_wb_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_e,
    output logic [4:0]        wb_idx,
    output logic [DATA_W-1:0] wb_out,
    output logic              err
);

    typedef enum logic {IDLE, MEM} state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [1:0]          mem_len_q, mem_len_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                ld_unsigned_q, ld_unsigned_d;
    logic                ld_wb_e_q, ld_wb_e_d;
    logic [4:0]          ld_wb_idx_q, ld_wb_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                wb_e_q, wb_e_d;
    logic [4:0]          wb_idx_q, wb_idx_d;
    logic [DATA_W-1:0]   wb_out_q, wb_out_d;
    logic                err_q, err_d;

    logic                accept_c;
    logic                size_bad_c;
    logic                misalign_c;

    // Keep the low (1 << len) bytes of d; fill the rest with the kept MSB or zero.
    function automatic logic [DATA_W-1:0] fit_bytes(input logic [DATA_W-1:0] d,
                                                     input logic [1:0]        len,
                                                     input logic              sgn);
        logic [DATA_W-1:0] mask;
        logic              msb;
        case (len)
            2'b00:   begin mask = DATA_W'(8'hFF);         msb = d[7];        end
            2'b01:   begin mask = DATA_W'(16'hFFFF);      msb = d[15];       end
            2'b10:   begin mask = DATA_W'(32'hFFFF_FFFF); msb = d[31];       end
            default: begin mask = '1;                     msb = d[DATA_W-1]; end
        endcase
        return (d & mask) | ({DATA_W{sgn & msb}} & ~mask);
    endfunction

    // Stage takes a new bundle only when idle and the output slot frees up this cycle.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    // 8-byte accesses do not fit a 32-bit datapath.
    assign size_bad_c = (in_rw_len == 2'b11) && (DATA_W < 32'd64);

`ifdef MA_ALIGN_CHECK_EN
    logic [2:0] lo_mask_c;

    // Address bits that must be zero for a naturally aligned access.
    always_comb begin
        case (in_rw_len)
            2'b00:   lo_mask_c = 3'b000;
            2'b01:   lo_mask_c = 3'b001;
            2'b10:   lo_mask_c = 3'b011;
            default: lo_mask_c = 3'b111;
        endcase
        misalign_c = |(in_ans[2:0] & lo_mask_c);
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Next-state and output-register logic.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_len_d     = mem_len_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        ld_unsigned_d = ld_unsigned_q;
        ld_wb_e_d     = ld_wb_e_q;
        ld_wb_idx_d   = ld_wb_idx_q;
        out_valid_d   = out_valid_q;
        wb_e_d        = wb_e_q;
        wb_idx_d      = wb_idx_q;
        wb_out_d      = wb_out_q;
        err_d         = err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (in_rw_e == 2'b00) begin
                        out_valid_d = 1'b1;
                        wb_e_d      = in_wb_e;
                        wb_idx_d    = in_wb_idx;
                        wb_out_d    = in_ans;
                        err_d       = 1'b0;
                    end else if (size_bad_c || misalign_c) begin
                        out_valid_d = 1'b1;
                        wb_e_d      = 1'b0;
                        wb_idx_d    = in_wb_idx;
                        wb_out_d    = '0;
                        err_d       = 1'b1;
                    end else begin
                        mem_req_d     = 1'b1;
                        mem_we_d      = (in_rw_e == 2'b01);
                        mem_len_d     = in_rw_len;
                        mem_addr_d    = in_ans[ADDR_W-1:0];
                        mem_wdata_d   = (in_rw_e == 2'b01) ? fit_bytes(in_din, in_rw_len, 1'b0) : '0;
                        ld_unsigned_d = in_rw_e[0];
                        ld_wb_e_d     = in_wb_e;
                        ld_wb_idx_d   = in_wb_idx;
                        state_d       = MEM;
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    err_d       = 1'b0;
                    wb_idx_d    = ld_wb_idx_q;
                    if (mem_we_q) begin
                        wb_e_d   = 1'b0;
                        wb_out_d = '0;
                    end else begin
                        wb_e_d   = ld_wb_e_q;
                        wb_out_d = fit_bytes(mem_rdata, mem_len_q, !ld_unsigned_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request and output registers; reset abandons any open transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_len_q     <= 2'b00;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            ld_unsigned_q <= 1'b0;
            ld_wb_e_q     <= 1'b0;
            ld_wb_idx_q   <= 5'd0;
            out_valid_q   <= 1'b0;
            wb_e_q        <= 1'b0;
            wb_idx_q      <= 5'd0;
            wb_out_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_len_q     <= mem_len_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            ld_unsigned_q <= ld_unsigned_d;
            ld_wb_e_q     <= ld_wb_e_d;
            ld_wb_idx_q   <= ld_wb_idx_d;
            out_valid_q   <= out_valid_d;
            wb_e_q        <= wb_e_d;
            wb_idx_q      <= wb_idx_d;
            wb_out_q      <= wb_out_d;
            err_q         <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_len   = mem_len_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign wb_e      = wb_e_q;
    assign wb_idx    = wb_idx_q;
    assign wb_out    = wb_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Testbench for pipe_mem_stage: scoreboard of expected WB bundles, popped
// whenever the DUT hands a bundle downstream; per-scenario tasks check the
// cache-side signals and handshakes inline.
module tb_pipe_mem_stage;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic        wb_e;
        logic [4:0]  idx;
        logic [63:0] val;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_rw_e;
    logic [1:0]        in_rw_len;
    logic [DATA_W-1:0] in_ans;
    logic [DATA_W-1:0] in_din;
    logic              in_wb_e;
    logic [4:0]        in_wb_idx;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic              wb_e;
    logic [4:0]        wb_idx;
    logic [DATA_W-1:0] wb_out;
    logic              err;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    pipe_mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rw_e(in_rw_e), .in_rw_len(in_rw_len),
        .in_ans(in_ans), .in_din(in_din),
        .in_wb_e(in_wb_e), .in_wb_idx(in_wb_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_e(wb_e), .wb_idx(wb_idx), .wb_out(wb_out), .err(err)
    );

    always #5 clk = ~clk;

    // Scoreboard: a bundle is consumed at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got bundle wb_out=%h err=%b, expected none", wb_out, err);
            end else begin
                mon_e = sb.pop_front();
                if ({wb_e, wb_idx, wb_out, err} !== {mon_e.wb_e, mon_e.idx, mon_e.val, mon_e.err}) begin
                    n_bad++;
                    $display("FAIL sb_bundle: got wb_e=%b idx=%0d out=%h err=%b, expected wb_e=%b idx=%0d out=%h err=%b",
                             wb_e, wb_idx, wb_out, err, mon_e.wb_e, mon_e.idx, mon_e.val, mon_e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic issue(input logic [1:0] rw, input logic [1:0] len, input logic [63:0] ans,
                         input logic [63:0] din, input logic wbe, input logic [4:0] idx);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_rw_e   = rw;
        in_rw_len = len;
        in_ans    = ans;
        in_din    = din;
        in_wb_e   = wbe;
        in_wb_idx = idx;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL issue_timeout: in_ready=%b after 20 cycles, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One cache transaction acked after dly request cycles.
    task automatic mem_op(input logic [1:0] rw, input logic [1:0] len, input logic [63:0] addr,
                          input logic [63:0] din, input logic [4:0] idx, input int dly,
                          input logic [63:0] rdata, input logic [63:0] exp_wdata,
                          input logic exp_wbe, input logic [63:0] exp_val, input string nm);
        exp_t e;
        logic [63:0] seen_wdata;
        e.wb_e = exp_wbe;
        e.idx  = idx;
        e.val  = exp_val;
        e.err  = 1'b0;
        sb.push_back(e);
        issue(rw, len, addr, din, 1'b1, idx);
        for (int k = 0; k < dly; k++) begin
            seen_wdata = (rw == 2'b01) ? mem_wdata : 64'h0;
            n_cmp++;
            if ({mem_req, mem_we, mem_len, mem_addr, seen_wdata, in_ready} !==
                {1'b1, (rw == 2'b01), len, addr[31:0], exp_wdata, 1'b0}) begin
                n_bad++;
                $display("FAIL %s_req%0d: got req=%b we=%b len=%b addr=%h wdata=%h in_ready=%b, expected req=1 we=%b len=%b addr=%h wdata=%h in_ready=0",
                         nm, k, mem_req, mem_we, mem_len, mem_addr, seen_wdata, in_ready,
                         (rw == 2'b01), len, addr[31:0], exp_wdata);
            end
            if (k == dly - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            cyc();
        end
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, out_valid} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s_done: got mem_req=%b out_valid=%b, expected mem_req=0 out_valid=1",
                     nm, mem_req, out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({mem_req, out_valid, err, wb_e, wb_idx, wb_out, mem_addr, mem_wdata, mem_we, mem_len} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b ov=%b err=%b wb_e=%b idx=%0d out=%h addr=%h wdata=%h, expected all 0",
                     mem_req, out_valid, err, wb_e, wb_idx, wb_out, mem_addr, mem_wdata);
        end
        cyc();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, mem_req} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b mem_req=%b, expected 1 0 0",
                     in_ready, out_valid, mem_req);
        end
    endtask

    task automatic test_passthrough();
        sb.push_back('{wb_e: 1'b1, idx: 5'd3, val: 64'h1234, err: 1'b0});
        issue(2'b00, 2'b00, 64'h1234, 64'h0, 1'b1, 5'd3);
        n_cmp++;
        if ({out_valid, wb_out, wb_idx, err, mem_req} !== {1'b1, 64'h1234, 5'd3, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL pass_latency: got ov=%b out=%h idx=%0d err=%b req=%b, expected 1 1234 3 0 0",
                     out_valid, wb_out, wb_idx, err, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        in_valid = 1'b1;
        in_rw_e  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            v         = 64'hA5A5_0000_0000_0000 + 64'(i * 17);
            in_ans    = v;
            in_wb_e   = i[0];
            in_wb_idx = 5'(10 + i);
            sb.push_back('{wb_e: i[0], idx: 5'(10 + i), val: v, err: 1'b0});
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_ready%0d: in_ready=%b, expected 1", i, in_ready);
            end
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load_ext();
        mem_op(2'b10, 2'b00, 64'h100, 64'h0, 5'd4, 3, 64'h80, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, "ld_sb");
        mem_op(2'b11, 2'b00, 64'h100, 64'h0, 5'd4, 3, 64'h80, 64'h0, 1'b1, 64'h80, "ld_ub");
        mem_op(2'b10, 2'b01, 64'h102, 64'h0, 5'd5, 1, 64'h8001, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_8001, "ld_sh");
        mem_op(2'b10, 2'b10, 64'h104, 64'h0, 5'd6, 2, 64'hDEAD_BEEF_7FFF_FFFF, 64'h0, 1'b1, 64'h7FFF_FFFF, "ld_sw");
        mem_op(2'b11, 2'b10, 64'h104, 64'h0, 5'd6, 1, 64'h1_8000_0000, 64'h0, 1'b1, 64'h8000_0000, "ld_uw");
        mem_op(2'b10, 2'b11, 64'h108, 64'h0, 5'd8, 1, 64'h8123_4567_89AB_CDEF, 64'h0, 1'b1, 64'h8123_4567_89AB_CDEF, "ld_sd");
    endtask

    task automatic test_store();
        mem_op(2'b01, 2'b01, 64'h202, 64'hABCD_1234, 5'd7, 2, 64'h0, 64'h1234, 1'b0, 64'h0, "st_h");
        mem_op(2'b01, 2'b00, 64'h11, 64'h1122_3344_5566_7788, 5'd1, 1, 64'h0, 64'h88, 1'b0, 64'h0, "st_b");
        mem_op(2'b01, 2'b10, 64'h204, 64'hFEDC_BA98_7654_3210, 5'd2, 1, 64'h0, 64'h7654_3210, 1'b0, 64'h0, "st_w");
        mem_op(2'b01, 2'b11, 64'h208, 64'hFEDC_BA98_7654_3210, 5'd2, 2, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b0, 64'h0, "st_d");
    endtask

    task automatic test_align();
`ifdef MA_ALIGN_CHECK_EN
        sb.push_back('{wb_e: 1'b0, idx: 5'd12, val: 64'h0, err: 1'b1});
        issue(2'b10, 2'b10, 64'h102, 64'h0, 1'b1, 5'd12);
        n_cmp++;
        if ({mem_req, out_valid, err, wb_e} !== 4'b0110) begin
            n_bad++;
            $display("FAIL align_fault: got req=%b ov=%b err=%b wb_e=%b, expected 0 1 1 0",
                     mem_req, out_valid, err, wb_e);
        end
`else
        mem_op(2'b10, 2'b10, 64'h102, 64'h0, 5'd12, 1, 64'h8765_4321, 64'h0, 1'b1,
               64'hFFFF_FFFF_8765_4321, "ld_misal");
`endif
    endtask

    task automatic test_backpressure_reset();
        // Stall the output, queue a second bundle behind it, then release.
        out_ready = 1'b0;
        sb.push_back('{wb_e: 1'b1, idx: 5'd9, val: 64'h55AA, err: 1'b0});
        issue(2'b00, 2'b00, 64'h55AA, 64'h0, 1'b1, 5'd9);
        in_valid  = 1'b1;
        in_rw_e   = 2'b00;
        in_ans    = 64'h66BB;
        in_wb_e   = 1'b1;
        in_wb_idx = 5'd11;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({out_valid, wb_e, wb_idx, wb_out, err, in_ready} !== {1'b1, 1'b1, 5'd9, 64'h55AA, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL stall%0d: got ov=%b idx=%0d out=%h err=%b in_ready=%b, expected 1 9 55aa 0 0",
                         k, out_valid, wb_idx, wb_out, err, in_ready);
            end
            cyc();
        end
        sb.push_back('{wb_e: 1'b1, idx: 5'd11, val: 64'h66BB, err: 1'b0});
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, wb_out} !== {1'b1, 64'h66BB}) begin
            n_bad++;
            $display("FAIL no_bubble: got ov=%b out=%h, expected 1 66bb", out_valid, wb_out);
        end
        cyc();
        // Abandon a load with reset while the request is open.
        issue(2'b10, 2'b10, 64'h300, 64'h0, 1'b1, 5'd13);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre_req: mem_req=%b, expected 1", mem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, out_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_async: got mem_req=%b out_valid=%b, expected 0 0", mem_req, out_valid);
        end
        cyc();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'h77;
        cyc();
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({out_valid, mem_req} !== 2'b00) begin
                n_bad++;
                $display("FAIL stray_ack%0d: got out_valid=%b mem_req=%b, expected 0 0", k, out_valid, mem_req);
            end
            cyc();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rw_e   = 2'b00;
        in_rw_len = 2'b00;
        in_ans    = '0;
        in_din    = '0;
        in_wb_e   = 1'b0;
        in_wb_idx = 5'd0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        test_reset();
        test_passthrough();
        test_back_to_back();
        test_load_ext();
        test_store();
        test_align();
        cyc();
        test_backpressure_reset();

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d bundles outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
